spi_master_arbiter: RTL and testbench

- Two-requester round-robin arbiter and transaction sequencer in front of the SPI_Master engine.
- Latches the granted requester's SPI mode, clock divider, length and TX word, then drives the master's config/data write strobes and its TX_DV start pulse.
- Waits for RX completion and returns the received word, with one chip-select per requester.
- Hides the master's edge-detected strobe timing from software-side requesters.

---
 rtl/spi_master_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_spi_master_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_arbiter.sv
// spi_master_arbiter: two-requester round-robin sequencer in front of the SPI_Master engine.
// Define SPI_ARB_TIMEOUT_EN to bound the BUSY wait by TIMEOUT_CYCLES.
module spi_master_arbiter #(
  parameter int unsigned WR_HOLD        = 3,
  parameter int unsigned CS_SETUP       = 2,
  parameter int unsigned CS_HOLD        = 2,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_req0,
  input  logic        i_req1,
  input  logic [1:0]  i_mode0,
  input  logic [1:0]  i_mode1,
  input  logic [15:0] i_ticks0,
  input  logic [15:0] i_ticks1,
  input  logic [3:0]  i_len0,
  input  logic [3:0]  i_len1,
  input  logic [15:0] i_data0,
  input  logic [15:0] i_data1,
  output logic [1:0]  o_gnt,
  output logic [1:0]  o_done,
  output logic        o_err,
  output logic [15:0] o_rdata,
  output logic [1:0]  o_CS_n,
  output logic        o_wr_cr,
  output logic        o_wr_data,
  output logic [1:0]  o_spi_mode,
  output logic [15:0] o_ticks_per_half_bit,
  output logic [3:0]  o_TX_data_length,
  output logic [3:0]  o_RX_data_length,
  output logic [15:0] o_TX_Data,
  output logic        o_TX_DV,
  input  logic        i_TX_Ready,
  input  logic        i_RX_DV,
  input  logic [15:0] i_RX_Data
);

`ifdef SPI_ARB_TIMEOUT_EN
  localparam bit TimeoutEn = 1'b1;
`else
  localparam bit TimeoutEn = 1'b0;
`endif

  localparam logic [15:0] WrLast     = 16'(WR_HOLD - 1);
  localparam logic [15:0] SettleLast = 16'(WR_HOLD);
  localparam logic [15:0] SuLast     = 16'(CS_SETUP - 1);
  localparam logic [15:0] HdLast     = 16'(CS_HOLD - 1);
  localparam logic [15:0] ToLast     = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, CFG, SETTLE, CSSU, START, BUSY, CSHD, DONE
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  gnt_q, gnt_d;
  logic        last_q, last_d;   // index of the requester granted most recently
  logic        err_q, err_d;
  logic [1:0]  mode_q, mode_d;
  logic [15:0] ticks_q, ticks_d;
  logic [3:0]  len_q, len_d;
  logic [15:0] data_q, data_d;
  logic [15:0] rdata_q, rdata_d;
  logic        pick1;

  // On contention req1 wins only if req0 was served last.
  assign pick1 = i_req1 & (~i_req0 | ~last_q);

  // NOTE: every _d gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    err_d   = err_q;
    mode_d  = mode_q;
    ticks_d = ticks_q;
    len_d   = len_q;
    data_d  = data_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (i_req0 | i_req1) begin
          gnt_d   = pick1 ? 2'b10 : 2'b01;
          mode_d  = pick1 ? i_mode1  : i_mode0;
          ticks_d = pick1 ? i_ticks1 : i_ticks0;
          len_d   = pick1 ? i_len1   : i_len0;
          data_d  = pick1 ? i_data1  : i_data0;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = CFG;
        end
      end
      CFG: begin
        if (cnt_q == WrLast) begin
          cnt_d   = '0;
          state_d = SETTLE;
        end else cnt_d = cnt_q + 16'd1;
      end
      SETTLE: begin
        // Low gap lets the master's two-flop edge detector rearm before the next strobe.
        if (cnt_q == SettleLast) begin
          cnt_d   = '0;
          state_d = CSSU;
        end else cnt_d = cnt_q + 16'd1;
      end
      CSSU: begin
        if (cnt_q >= SuLast) begin
          if (i_TX_Ready) begin
            cnt_d   = '0;
            state_d = START;
          end
        end else cnt_d = cnt_q + 16'd1;
      end
      START: begin
        cnt_d   = '0;
        state_d = BUSY;
      end
      BUSY: begin
        if (i_RX_DV) begin
          rdata_d = i_RX_Data;
          cnt_d   = '0;
          state_d = CSHD;
        end else if (TimeoutEn && cnt_q == ToLast) begin
          rdata_d = 16'hFFFF;
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = CSHD;
        end else cnt_d = cnt_q + 16'd1;
      end
      CSHD: begin
        if (cnt_q == HdLast) begin
          cnt_d   = '0;
          state_d = DONE;
        end else cnt_d = cnt_q + 16'd1;
      end
      DONE: begin
        last_d  = gnt_q[1];
        gnt_d   = 2'b00;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gnt_q   <= '0;
      last_q  <= 1'b1;
      err_q   <= 1'b0;
      mode_q  <= '0;
      ticks_q <= '0;
      len_q   <= '0;
      data_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      err_q   <= err_d;
      mode_q  <= mode_d;
      ticks_q <= ticks_d;
      len_q   <= len_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
    end
  end

  assign o_gnt                = gnt_q;
  assign o_done               = (state_q == DONE) ? gnt_q : 2'b00;
  assign o_err                = (state_q == DONE) & err_q;
  assign o_rdata              = rdata_q;
  assign o_CS_n               = (state_q inside {CSSU, START, BUSY, CSHD}) ? ~gnt_q : 2'b11;
  assign o_wr_cr              = (state_q == CFG);
  assign o_wr_data            = (state_q == CFG);
  assign o_TX_DV              = (state_q == START);
  assign o_spi_mode           = mode_q;
  assign o_ticks_per_half_bit = ticks_q;
  assign o_TX_data_length     = len_q;
  assign o_RX_data_length     = len_q;
  assign o_TX_Data            = data_q;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Directed self-checking bench for spi_master_arbiter with a hand-driven SPI master model.
module tb_spi_master_arbiter;
  logic        i_Clk = 1'b0;
  logic        i_Rst;
  logic        i_req0, i_req1;
  logic [1:0]  i_mode0, i_mode1;
  logic [15:0] i_ticks0, i_ticks1;
  logic [3:0]  i_len0, i_len1;
  logic [15:0] i_data0, i_data1;
  logic [1:0]  o_gnt, o_done, o_CS_n, o_spi_mode;
  logic        o_err, o_wr_cr, o_wr_data, o_TX_DV;
  logic [15:0] o_rdata, o_ticks_per_half_bit, o_TX_Data;
  logic [3:0]  o_TX_data_length, o_RX_data_length;
  logic        i_TX_Ready, i_RX_DV;
  logic [15:0] i_RX_Data;

  int checks = 0;
  int failures = 0;
  int done_pulses = 0;
  int err_pulses = 0;
  bit mon_en = 1'b0;

  always #5 i_Clk = ~i_Clk;

  spi_master_arbiter #(.TIMEOUT_CYCLES(50)) dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst),
    .i_req0(i_req0), .i_req1(i_req1),
    .i_mode0(i_mode0), .i_mode1(i_mode1),
    .i_ticks0(i_ticks0), .i_ticks1(i_ticks1),
    .i_len0(i_len0), .i_len1(i_len1),
    .i_data0(i_data0), .i_data1(i_data1),
    .o_gnt(o_gnt), .o_done(o_done), .o_err(o_err), .o_rdata(o_rdata),
    .o_CS_n(o_CS_n), .o_wr_cr(o_wr_cr), .o_wr_data(o_wr_data),
    .o_spi_mode(o_spi_mode), .o_ticks_per_half_bit(o_ticks_per_half_bit),
    .o_TX_data_length(o_TX_data_length), .o_RX_data_length(o_RX_data_length),
    .o_TX_Data(o_TX_Data), .o_TX_DV(o_TX_DV),
    .i_TX_Ready(i_TX_Ready), .i_RX_DV(i_RX_DV), .i_RX_Data(i_RX_Data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge i_Clk);
  endtask

  // Grant must stay at most one-hot and done may only go to the granted requester.
  always @(negedge i_Clk) begin
    if (mon_en) begin
      check("gnt_onehot", 32'($countones(o_gnt) <= 1), 32'd1);
      if (o_done != 2'b00) begin
        done_pulses++;
        check("done_to_gnt", 32'(o_done & ~o_gnt), 32'd0);
      end
      if (o_err) err_pulses++;
    end
  end

  // Waits for TX_DV, optionally drops requests in BUSY, returns RX word after busy_wait cycles.
  task automatic serve(input logic [15:0] rx, input int busy_wait, input logic [1:0] drop,
                       output logic [1:0] g, output logic [15:0] tx,
                       output logic [1:0] d, output int gap);
    int n;
    n = 0;
    g = 2'b00; tx = 16'h0; d = 2'b00; gap = -1;
    while (!o_TX_DV && n < 300) begin n++; step(); end
    if (!o_TX_DV) begin
      check("txdv_wait_expired", 32'd0, 32'd1);
      return;
    end
    g  = o_gnt;
    tx = o_TX_Data;
    step();
    if (drop[0]) i_req0 = 1'b0;
    if (drop[1]) i_req1 = 1'b0;
    repeat (busy_wait) step();
    i_RX_DV = 1'b1; i_RX_Data = rx;
    step();
    i_RX_DV = 1'b0; i_RX_Data = 16'h0;
    gap = 0;
    while (o_done == 2'b00 && gap < 50) begin gap++; step(); end
    d = o_done;
  endtask

  initial begin
    int n, bad, snap, gap;
    logic [1:0] g, d, expg;
    logic [15:0] tx;

    i_Rst = 1'b1;
    i_req0 = 0; i_req1 = 0;
    i_mode0 = 0; i_mode1 = 0; i_ticks0 = 0; i_ticks1 = 0;
    i_len0 = 0; i_len1 = 0; i_data0 = 0; i_data1 = 0;
    i_TX_Ready = 1'b1; i_RX_DV = 1'b0; i_RX_Data = 16'h0;
    step(); step();
    check("rst_gnt", 32'(o_gnt), 32'h0);
    check("rst_cs", 32'(o_CS_n), 32'h3);
    check("rst_done", 32'(o_done), 32'h0);
    check("rst_rdata", 32'(o_rdata), 32'h0);
    check("rst_strobes", 32'({o_wr_cr, o_wr_data, o_TX_DV, o_err}), 32'h0);
    check("rst_cfg", 32'({o_spi_mode, o_ticks_per_half_bit, o_TX_Data}), 32'h0);
    i_Rst = 1'b0;
    mon_en = 1'b1;

    // Single transaction on req0.
    i_req0 = 1; i_mode0 = 2'd1; i_ticks0 = 16'd4; i_len0 = 4'd7; i_data0 = 16'h00A5;
    step();
    check("t1_gnt", 32'(o_gnt), 32'h1);
    check("t1_mode", 32'(o_spi_mode), 32'h1);
    check("t1_ticks", 32'(o_ticks_per_half_bit), 32'h4);
    check("t1_len", 32'({o_TX_data_length, o_RX_data_length}), 32'h77);
    check("t1_txdata", 32'(o_TX_Data), 32'h00A5);
    check("t1_wr_data", 32'(o_wr_data), 32'h1);
    n = 0;
    while (o_wr_cr && n < 20) begin n++; step(); end
    check("t1_wr_high", 32'(n), 32'd3);
    n = 0; bad = 0;
    while (o_CS_n[0] && n < 20) begin if (o_wr_cr || o_wr_data) bad++; n++; step(); end
    check("t1_wr_low", 32'(n), 32'd4);
    check("t1_wr_low_clean", 32'(bad), 32'd0);
    n = 0;
    while (!o_TX_DV && n < 20) begin if (o_CS_n[0]) bad++; n++; step(); end
    check("t1_cs_setup", 32'(n), 32'd2);
    check("t1_cs_n", 32'(o_CS_n), 32'h2);
    step();
    check("t1_txdv_single", 32'(o_TX_DV), 32'h0);
    repeat (3) step();
    i_RX_DV = 1; i_RX_Data = 16'h003C;
    step();
    i_RX_DV = 0; i_RX_Data = 16'h0;
    gap = 0;
    while (o_done == 2'b00 && gap < 50) begin
      if (o_CS_n != 2'b10) bad++;
      gap++; step();
    end
    check("t1_done_gap", 32'(gap), 32'd2);
    check("t1_cs_hold", 32'(bad), 32'd0);
    check("t1_done", 32'(o_done), 32'h1);
    check("t1_rdata", 32'(o_rdata), 32'h003C);
    check("t1_done_cs", 32'(o_CS_n), 32'h3);
    i_req0 = 0;
    step();
    check("t1_done_1cyc", 32'(o_done), 32'h0);

    // Request drop: req1 deasserts in BUSY; transaction still completes.
    i_req1 = 1; i_mode1 = 2'd2; i_ticks1 = 16'd9; i_len1 = 4'd15; i_data1 = 16'hBEEF;
    step();
    check("t2_mode", 32'(o_spi_mode), 32'h2);
    check("t2_len", 32'(o_RX_data_length), 32'hF);
    serve(16'h1234, 4, 2'b10, g, tx, d, gap);
    check("t2_gnt", 32'(g), 32'h2);
    check("t2_tx", 32'(tx), 32'hBEEF);
    check("t2_done", 32'(d), 32'h2);
    check("t2_rdata", 32'(o_rdata), 32'h1234);
    repeat (10) step();
    check("t2_no_regrant", 32'({o_gnt, o_CS_n}), 32'h3);

    // Contention: both held, pointer last served req1 so order is 0,1,0,1.
    i_mode0 = 2'd0; i_data0 = 16'h1111; i_mode1 = 2'd3; i_data1 = 16'h2222;
    i_req0 = 1; i_req1 = 1;
    for (int k = 0; k < 4; k++) begin
      expg = (k % 2 == 0) ? 2'b01 : 2'b10;
      serve(16'h0100 + 16'(k), 2, 2'b00, g, tx, d, gap);
      check("t3_gnt", 32'(g), 32'(expg));
      check("t3_tx", 32'(tx), (k % 2 == 0) ? 32'h1111 : 32'h2222);
      check("t3_done", 32'(d), 32'(expg));
      check("t3_rdata", 32'(o_rdata), 32'h0100 + 32'(k));
    end
    i_req0 = 0; i_req1 = 0;
    step();

    // TX_Ready stall in CSSU.
    i_TX_Ready = 0; i_req0 = 1; i_data0 = 16'h5A5A;
    n = 0;
    while (o_CS_n[0] && n < 50) begin n++; step(); end
    check("t4_cs_low", 32'(o_CS_n), 32'h2);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      if (o_CS_n != 2'b10 || o_TX_DV) bad++;
      step();
    end
    check("t4_stall", 32'(bad), 32'd0);
    i_TX_Ready = 1;
    step();
    check("t4_txdv_after_ready", 32'(o_TX_DV), 32'h1);
    check("t4_cs_at_start", 32'(o_CS_n), 32'h2);
    serve(16'hC0DE, 1, 2'b00, g, tx, d, gap);
    check("t4_done", 32'(d), 32'h1);
    check("t4_rdata", 32'(o_rdata), 32'hC0DE);
    i_req0 = 0;
    step();

    // Async reset mid-BUSY.
    i_req0 = 1; i_data0 = 16'h7777;
    n = 0;
    while (!o_TX_DV && n < 100) begin n++; step(); end
    check("t5_reached_start", 32'(o_TX_DV), 32'h1);
    step(); step();
    snap = done_pulses;
    #2 i_Rst = 1;
    #1;
    check("t5_rst_cs", 32'(o_CS_n), 32'h3);
    check("t5_rst_gnt", 32'(o_gnt), 32'h0);
    step(); step();
    i_Rst = 0;
    step();
    check("t5_no_done", 32'(done_pulses), 32'(snap));
    check("t5_restart_cfg", 32'({o_gnt, o_wr_cr}), 32'h3);
    serve(16'h4242, 2, 2'b00, g, tx, d, gap);
    check("t5_done", 32'(d), 32'h1);
    check("t5_rdata", 32'(o_rdata), 32'h4242);
    i_req0 = 0;
    step();

`ifdef SPI_ARB_TIMEOUT_EN
    // Timeout: no RX_DV ever arrives.
    i_req0 = 1;
    n = 0;
    while (o_done == 2'b00 && n < 300) begin n++; step(); end
    check("t6_done", 32'(o_done), 32'h1);
    check("t6_err", 32'(o_err), 32'h1);
    check("t6_rdata", 32'(o_rdata), 32'hFFFF);
    i_req0 = 0;
    step();
    check("t6_err_1cyc", 32'({o_err, o_done}), 32'h0);
    check("err_pulses", 32'(err_pulses), 32'd1);
`else
    check("err_pulses", 32'(err_pulses), 32'd0);
`endif

    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end
endmodule
